// File: rtl/v_vmem_arbiter_pkg.sv
// Shared types for the vector-memory arbiter slice: requester id and
// the largest supported memory read latency.
package v_mem_pkg;

   typedef enum logic {
      VMEM_ID_P0 = 1'b0,
      VMEM_ID_P1 = 1'b1
   } vmem_id_e;

   localparam int unsigned VMEM_RD_LAT_MAX = 8;

endpackage

// File: rtl/v_vmem_arbiter_if.sv
// Requester/memory bus of the vector-memory arbiter. The arbiter takes the
// slave view; requesters plus the memory model take the master view.
interface v_vmem_arbiter_if #(
   parameter int unsigned VMEM_DW = 512,
   parameter int unsigned VMEM_AW = 64
) ();

   logic               p0_req_i;
   logic               p0_we_i;
   logic [VMEM_AW-1:0] p0_addr_i;
   logic [VMEM_DW-1:0] p0_wdata_i;
   logic               p0_gnt_o;
   logic               p0_rvalid_o;
   logic [VMEM_DW-1:0] p0_rdata_o;

   logic               p1_req_i;
   logic               p1_we_i;
   logic [VMEM_AW-1:0] p1_addr_i;
   logic [VMEM_DW-1:0] p1_wdata_i;
   logic               p1_gnt_o;
   logic               p1_rvalid_o;
   logic [VMEM_DW-1:0] p1_rdata_o;

   logic               mem_en_o;
   logic               mem_we_o;
   logic [VMEM_AW-1:0] mem_addr_o;
   logic [VMEM_DW-1:0] mem_wdata_o;
   logic               mem_ready_i;
   logic [VMEM_DW-1:0] mem_rdata_i;

   logic               busy_o;

   modport slave (
      input  p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
      output p0_gnt_o, p0_rvalid_o, p0_rdata_o,
      input  p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
      output p1_gnt_o, p1_rvalid_o, p1_rdata_o,
      output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_ready_i, mem_rdata_i,
      output busy_o
   );

   modport master (
      output p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
      input  p0_gnt_o, p0_rvalid_o, p0_rdata_o,
      output p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
      input  p1_gnt_o, p1_rvalid_o, p1_rdata_o,
      input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_ready_i, mem_rdata_i,
      input  busy_o
   );

endinterface

// File: rtl/v_vmem_arbiter_rr_arb2.sv
// Two-way round-robin selector. The pointer only moves on an accepted
// access, and then points at the port that did not win.
module v_rr_arb2
   import v_mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output vmem_id_e   sel_o
);

   vmem_id_e ptr_q, ptr_d;

   // Winner: sole requester, or the favoured port when both request.
   always_comb begin
      sel_o = VMEM_ID_P0;
      case (req_i)
         2'b01:   sel_o = VMEM_ID_P0;
         2'b10:   sel_o = VMEM_ID_P1;
         2'b11:   sel_o = ptr_q;
         default: sel_o = VMEM_ID_P0;
      endcase
   end

   // Favour the losing port after every accepted access.
   always_comb begin
      ptr_d = ptr_q;
      if (accept_i) begin
         ptr_d = (sel_o == VMEM_ID_P0) ? VMEM_ID_P1 : VMEM_ID_P0;
      end
   end

   // Pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= VMEM_ID_P0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/v_vmem_arbiter.sv
// Vector-memory arbiter: shares one memory port between vector load/store
// issue (port 0) and the DMA/host fill engine (port 1), and routes load
// returns back through a fixed-latency tag pipe.
// Optional macro VMEM_ARB_PERF_EN adds saturating grant/conflict counters.
module v_vmem_arbiter
   import v_mem_pkg::*;
#(
   parameter int unsigned VMEM_DW = 512,
   parameter int unsigned VMEM_AW = 64,
   parameter int unsigned RD_LAT  = 1,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   v_vmem_arbiter_if.slave      bus
`ifdef VMEM_ARB_PERF_EN
   ,
   output logic [CNT_W-1:0]     perf_gnt0_o,
   output logic [CNT_W-1:0]     perf_gnt1_o,
   output logic [CNT_W-1:0]     perf_conflict_o
`endif
);

   // Out-of-range latencies are clamped to 1..VMEM_RD_LAT_MAX so the pipe
   // always has at least one stage.
   localparam int unsigned LAT = (RD_LAT == 0) ? 1 :
                                 ((RD_LAT > VMEM_RD_LAT_MAX) ? VMEM_RD_LAT_MAX : RD_LAT);

   vmem_id_e           sel;
   logic               accept;
   logic               m_en;
   logic               m_we;
   logic [VMEM_AW-1:0] m_addr;
   logic [VMEM_DW-1:0] m_wdata;
   logic [LAT-1:0]     vld_q, vld_d;
   logic [LAT-1:0]     id_q, id_d;

   v_rr_arb2 u_rr (
      .clk      (clk),
      .rst      (rst),
      .req_i    ({bus.p1_req_i, bus.p0_req_i}),
      .accept_i (accept),
      .sel_o    (sel)
   );

   // Memory request mux; everything is zero when nobody requests.
   always_comb begin
      m_en    = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      if (bus.p0_req_i || bus.p1_req_i) begin
         m_en = 1'b1;
         if (sel == VMEM_ID_P1) begin
            m_we    = bus.p1_we_i;
            m_addr  = bus.p1_addr_i;
            m_wdata = bus.p1_wdata_i;
         end else begin
            m_we    = bus.p0_we_i;
            m_addr  = bus.p0_addr_i;
            m_wdata = bus.p0_wdata_i;
         end
      end
   end

   assign accept          = m_en & bus.mem_ready_i;
   assign bus.mem_en_o    = m_en;
   assign bus.mem_we_o    = m_we;
   assign bus.mem_addr_o  = m_addr;
   assign bus.mem_wdata_o = m_wdata;
   assign bus.p0_gnt_o    = accept & (sel == VMEM_ID_P0);
   assign bus.p1_gnt_o    = accept & (sel == VMEM_ID_P1);

   // Return tag pipe: accepted loads enter stage 0 and shift every cycle.
   always_comb begin
      vld_d    = '0;
      id_d     = '0;
      vld_d[0] = accept & ~m_we;
      id_d[0]  = (sel == VMEM_ID_P1);
      for (int unsigned i = 1; i < LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         id_d[i]  = id_q[i-1];
      end
   end

   // Tag pipe registers; reset drops every in-flight load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         id_q  <= '0;
      end else begin
         vld_q <= vld_d;
         id_q  <= id_d;
      end
   end

   assign bus.p0_rvalid_o = vld_q[LAT-1] & ~id_q[LAT-1];
   assign bus.p1_rvalid_o = vld_q[LAT-1] &  id_q[LAT-1];
   assign bus.p0_rdata_o  = bus.mem_rdata_i;
   assign bus.p1_rdata_o  = bus.mem_rdata_i;
   assign bus.busy_o      = |vld_q;

`ifdef VMEM_ARB_PERF_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] gnt0_cnt_q, gnt0_cnt_d;
   logic [CNT_W-1:0] gnt1_cnt_q, gnt1_cnt_d;
   logic [CNT_W-1:0] conf_cnt_q, conf_cnt_d;

   // Saturating event counters; with both ports requesting one always loses.
   always_comb begin
      gnt0_cnt_d = gnt0_cnt_q;
      gnt1_cnt_d = gnt1_cnt_q;
      conf_cnt_d = conf_cnt_q;
      if (bus.p0_gnt_o && !(&gnt0_cnt_q)) gnt0_cnt_d = gnt0_cnt_q + CNT_ONE;
      if (bus.p1_gnt_o && !(&gnt1_cnt_q)) gnt1_cnt_d = gnt1_cnt_q + CNT_ONE;
      if (bus.p0_req_i && bus.p1_req_i && !(&conf_cnt_q)) conf_cnt_d = conf_cnt_q + CNT_ONE;
   end

   // Counter registers, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt0_cnt_q <= '0;
         gnt1_cnt_q <= '0;
         conf_cnt_q <= '0;
      end else begin
         gnt0_cnt_q <= gnt0_cnt_d;
         gnt1_cnt_q <= gnt1_cnt_d;
         conf_cnt_q <= conf_cnt_d;
      end
   end

   assign perf_gnt0_o     = gnt0_cnt_q;
   assign perf_gnt1_o     = gnt1_cnt_q;
   assign perf_conflict_o = conf_cnt_q;
`endif

endmodule
